control_fsm: RTL and testbench

Multicycle control unit for the 16-bit RISC datapath. It drives every mux select and register enable of the datapath. It consumes the instruction register (`IRout`) and the ALU equality flag (`compare`), and sequences fetch, decode, execute, memory and write-back across several cycles per instruction. It owns the 3-bit `counter` used by LM/SM, and is the only block that steers the datapath.

---
 rtl/ctrl_pkg.sv | 110 +++++++++++
 rtl/ctrl_decode.sv | 137 +++++++++++++
 rtl/control_fsm.sv | 108 ++++++++++
 tb/tb_control_fsm.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle control unit.
// Holds the FSM state enum, opcode constants, the named encodings of every
// datapath select, and the packed control vector driven by ctrl_decode.
package ctrl_pkg;

  typedef enum logic [4:0] {
    StRst,
    StFAddr,
    StFIr,
    StPcWb,
    StAluEx,
    StAluWb,
    StAdiEx,
    StAdiWb,
    StLhiEx,
    StLhiWb,
    StAddr,
    StLwMem,
    StSwMem,
    StMAddr,
    StMXfer,
    StBeqCmp,
    StBrTgt,
    StJLink,
    StBrWb
  } state_e;

  // Opcodes (IR[15:12])
  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpAdi = 4'b0001;
  localparam logic [3:0] OpNdu = 4'b0010;
  localparam logic [3:0] OpLhi = 4'b0011;
  localparam logic [3:0] OpLw  = 4'b0100;
  localparam logic [3:0] OpSw  = 4'b0101;
  localparam logic [3:0] OpLm  = 4'b0110;
  localparam logic [3:0] OpSm  = 4'b0111;
  localparam logic [3:0] OpJal = 4'b1000;
  localparam logic [3:0] OpJlr = 4'b1001;
  localparam logic [3:0] OpBeq = 4'b1100;

  // ALU B select
  localparam logic [2:0] AluBZero    = 3'd0;
  localparam logic [2:0] AluBOne     = 3'd1;
  localparam logic [2:0] AluBRegB    = 3'd2;
  localparam logic [2:0] AluBImm6    = 3'd3;
  localparam logic [2:0] AluBCounter = 3'd4;

  // ALU A select
  localparam logic [2:0] AluAZero   = 3'd0;
  localparam logic [2:0] AluAOne    = 3'd1;
  localparam logic [2:0] AluAShift7 = 3'd2;
  localparam logic [2:0] AluAImm6   = 3'd3;
  localparam logic [2:0] AluAImm9   = 3'd4;
  localparam logic [2:0] AluARegA   = 3'd5;
  localparam logic [2:0] AluATmpA   = 3'd6;

  // RF write enable
  localparam logic [1:0] RfWenOff   = 2'd0;
  localparam logic [1:0] RfWenOn    = 2'd1;
  localparam logic [1:0] RfWenCz    = 2'd2;
  localparam logic [1:0] RfWenIrCnt = 2'd3;

  // RF write address
  localparam logic [2:0] WaddrRa  = 3'd0;  // IR[11:9]
  localparam logic [2:0] WaddrRc  = 3'd1;  // IR[5:3]
  localparam logic [2:0] WaddrCnt = 3'd2;
  localparam logic [2:0] WaddrR7  = 3'd3;
  localparam logic [2:0] WaddrRb  = 3'd4;  // IR[8:6]

  // RF read port 2 address
  localparam logic [1:0] Rd2Rb  = 2'd0;  // IR[8:6]
  localparam logic [1:0] Rd2Cnt = 2'd1;
  localparam logic [1:0] Rd2R7  = 2'd2;

  // RF write data
  localparam logic RfDinMem = 1'b0;
  localparam logic RfDinT1  = 1'b1;

  // Memory write enable
  localparam logic [1:0] MemWrOff   = 2'd0;
  localparam logic [1:0] MemWrOn    = 2'd1;
  localparam logic [1:0] MemWrIrCnt = 2'd2;

  // Memory write data
  localparam logic MemDinA = 1'b0;
  localparam logic MemDinB = 1'b1;

  // ALU operation
  localparam logic AluAdd  = 1'b0;
  localparam logic AluNand = 1'b1;

  typedef struct packed {
    logic [2:0] alu_b;
    logic [2:0] alu_a;
    logic [1:0] rf_wen;
    logic [2:0] rf_wadd;
    logic [1:0] rf_read2;
    logic       rf_din;
    logic [1:0] mem_wr;
    logic       mem_din;
    logic       cz_en;
    logic       alu_op;
    logic       w_ir;
    logic       w_atmp;
    logic       t1_write;
  } ctrl_t;

  localparam ctrl_t CtrlIdle = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of FSM state (plus opcode) into the datapath control
// vector.
// Ports:
//   state_i   current FSM state
//   opcode_i  IR[15:12], used where one state serves two instructions
//   ctrl_o    all mux selects and enables for the datapath
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [3:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = CtrlIdle;
    case (state_i)
      StFAddr: begin
        ctrl_o.rf_read2 = Rd2R7;
        ctrl_o.alu_a    = AluAZero;
        ctrl_o.alu_b    = AluBRegB;
        ctrl_o.t1_write = 1'b1;
      end
      StFIr: begin
        ctrl_o.w_ir     = 1'b1;
        ctrl_o.rf_read2 = Rd2R7;  // B operand must be R7 for PC+1
        ctrl_o.alu_a    = AluAOne;
        ctrl_o.alu_b    = AluBRegB;
        ctrl_o.t1_write = 1'b1;
      end
      StPcWb: begin
        ctrl_o.rf_wen  = RfWenOn;
        ctrl_o.rf_wadd = WaddrR7;
        ctrl_o.rf_din  = RfDinT1;
        ctrl_o.w_atmp  = 1'b1;
      end
      StAluEx: begin
        ctrl_o.alu_a    = AluARegA;
        ctrl_o.alu_b    = AluBRegB;
        ctrl_o.rf_read2 = Rd2Rb;
        ctrl_o.cz_en    = 1'b1;
        ctrl_o.t1_write = 1'b1;
        ctrl_o.alu_op   = (opcode_i == OpNdu) ? AluNand : AluAdd;
      end
      StAluWb: begin
        ctrl_o.rf_wen  = RfWenCz;
        ctrl_o.rf_wadd = WaddrRc;
        ctrl_o.rf_din  = RfDinT1;
      end
      StAdiEx: begin
        ctrl_o.alu_a    = AluARegA;
        ctrl_o.alu_b    = AluBImm6;
        ctrl_o.cz_en    = 1'b1;
        ctrl_o.t1_write = 1'b1;
      end
      StAdiWb: begin
        ctrl_o.rf_wen  = RfWenOn;
        ctrl_o.rf_wadd = WaddrRb;
        ctrl_o.rf_din  = RfDinT1;
      end
      StLhiEx: begin
        ctrl_o.alu_a    = AluAShift7;
        ctrl_o.alu_b    = AluBZero;
        ctrl_o.t1_write = 1'b1;
      end
      StLhiWb: begin
        ctrl_o.rf_wen  = RfWenOn;
        ctrl_o.rf_wadd = WaddrRa;
        ctrl_o.rf_din  = RfDinT1;
      end
      StAddr: begin
        ctrl_o.alu_a    = AluAImm6;
        ctrl_o.alu_b    = AluBRegB;
        ctrl_o.rf_read2 = Rd2Rb;
        ctrl_o.t1_write = 1'b1;
      end
      StLwMem: begin
        ctrl_o.rf_wen  = RfWenOn;
        ctrl_o.rf_wadd = WaddrRa;
        ctrl_o.rf_din  = RfDinMem;
      end
      StSwMem: begin
        ctrl_o.mem_wr  = MemWrOn;
        ctrl_o.mem_din = MemDinA;
      end
      StMAddr: begin
        ctrl_o.alu_a    = AluATmpA;
        ctrl_o.alu_b    = AluBCounter;
        ctrl_o.t1_write = 1'b1;
      end
      StMXfer: begin
        if (opcode_i == OpLm) begin
          ctrl_o.rf_wen  = RfWenIrCnt;
          ctrl_o.rf_wadd = WaddrCnt;
          ctrl_o.rf_din  = RfDinMem;
        end else begin
          ctrl_o.mem_wr   = MemWrIrCnt;
          ctrl_o.rf_read2 = Rd2Cnt;
          ctrl_o.mem_din  = MemDinB;
        end
      end
      StBeqCmp: begin
        ctrl_o.alu_a    = AluARegA;
        ctrl_o.alu_b    = AluBRegB;
        ctrl_o.rf_read2 = Rd2Rb;
      end
      StBrTgt: begin
        ctrl_o.alu_a    = AluAImm6;
        ctrl_o.alu_b    = AluBRegB;
        ctrl_o.rf_read2 = Rd2R7;
        ctrl_o.t1_write = 1'b1;
      end
      StJLink: begin
        // Link write uses the PC+1 still in T1 while T1 captures the target.
        ctrl_o.rf_wen   = RfWenOn;
        ctrl_o.rf_wadd  = WaddrRa;
        ctrl_o.rf_din   = RfDinT1;
        ctrl_o.alu_b    = AluBRegB;
        ctrl_o.t1_write = 1'b1;
        if (opcode_i == OpJal) begin
          ctrl_o.alu_a    = AluAImm9;
          ctrl_o.rf_read2 = Rd2R7;
        end else begin
          ctrl_o.alu_a    = AluAZero;
          ctrl_o.rf_read2 = Rd2Rb;
        end
      end
      StBrWb: begin
        ctrl_o.rf_wen  = RfWenOn;
        ctrl_o.rf_wadd = WaddrR7;
        ctrl_o.rf_din  = RfDinT1;
      end
      default: ctrl_o = CtrlIdle;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control unit for the 16-bit RISC datapath. Sequences fetch,
// decode, execute, memory and write-back, and owns the LM/SM slot counter.
// Ports:
//   clk, proc_rst       clock and synchronous active-high reset
//   IRout, compare      instruction register and ALU equality flag
//   Mux1..Mux9          datapath select lines
//   CZ_en, ALU_op, wIR, wAtmp, T1write  datapath enables / ALU op
//   counter             LM/SM register index
module control_fsm
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        proc_rst,
  input  logic [15:0] IRout,
  input  logic        compare,
  output logic [2:0]  Mux1_alu_B,
  output logic [2:0]  Mux2_alu_A,
  output logic [1:0]  Mux3_RF_wen,
  output logic [2:0]  Mux4_RF_wadd,
  output logic [1:0]  Mux5_RF_read2,
  output logic        Mux6_RF_dataIn,
  output logic [1:0]  Mux8_memwrite,
  output logic        Mux9_memDataIn,
  output logic        CZ_en,
  output logic        ALU_op,
  output logic        wIR,
  output logic        wAtmp,
  output logic        T1write,
  output logic [2:0]  counter
);

  state_e     state_q, state_d;
  logic [2:0] counter_q, counter_d;
  logic [3:0] opcode;
  ctrl_t      ctrl;
  logic       unused_ir;

  assign opcode    = IRout[15:12];
  assign unused_ir = ^IRout[11:0];

  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state_q   <= StRst;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    case (state_q)
      StRst:   state_d = StFAddr;
      StFAddr: state_d = StFIr;
      StFIr:   state_d = StPcWb;
      StPcWb: begin
        counter_d = '0;
        case (opcode)
          OpAdd, OpNdu: state_d = StAluEx;
          OpAdi:        state_d = StAdiEx;
          OpLhi:        state_d = StLhiEx;
          OpLw, OpSw:   state_d = StAddr;
          OpLm, OpSm:   state_d = StMAddr;
          OpBeq:        state_d = StBeqCmp;
          OpJal, OpJlr: state_d = StJLink;
          default:      state_d = StFAddr;  // undefined opcode acts as NOP
        endcase
      end
      StAluEx: state_d = StAluWb;
      StAdiEx: state_d = StAdiWb;
      StLhiEx: state_d = StLhiWb;
      StAddr:  state_d = (opcode == OpLw) ? StLwMem : StSwMem;
      StMAddr: state_d = StMXfer;
      StMXfer: begin
        counter_d = counter_q + 3'd1;  // wraps 7 -> 0 on the last slot
        state_d   = (counter_q == 3'd7) ? StFAddr : StMAddr;
      end
      StBeqCmp: state_d = compare ? StBrTgt : StFAddr;
      StBrTgt, StJLink: state_d = StBrWb;
      StAluWb, StAdiWb, StLhiWb, StLwMem, StSwMem, StBrWb: state_d = StFAddr;
      default: state_d = StRst;
    endcase
  end

  ctrl_decode u_ctrl_decode (
    .state_i  (state_q),
    .opcode_i (opcode),
    .ctrl_o   (ctrl)
  );

  assign Mux1_alu_B     = ctrl.alu_b;
  assign Mux2_alu_A     = ctrl.alu_a;
  assign Mux3_RF_wen    = ctrl.rf_wen;
  assign Mux4_RF_wadd   = ctrl.rf_wadd;
  assign Mux5_RF_read2  = ctrl.rf_read2;
  assign Mux6_RF_dataIn = ctrl.rf_din;
  assign Mux8_memwrite  = ctrl.mem_wr;
  assign Mux9_memDataIn = ctrl.mem_din;
  assign CZ_en          = ctrl.cz_en;
  assign ALU_op         = ctrl.alu_op;
  assign wIR            = ctrl.w_ir;
  assign wAtmp          = ctrl.w_atmp;
  assign T1write        = ctrl.t1_write;
  assign counter        = counter_q;

endmodule

// File: tb/tb_control_fsm.sv
// Randomized bench for control_fsm. The reference model expands each
// instruction into its expected per-cycle control vectors (micro-op script),
// including mid-instruction resets.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        proc_rst;
  logic [15:0] IRout;
  logic        compare;
  logic [2:0]  Mux1_alu_B, Mux2_alu_A, Mux4_RF_wadd, counter;
  logic [1:0]  Mux3_RF_wen, Mux5_RF_read2, Mux8_memwrite;
  logic        Mux6_RF_dataIn, Mux9_memDataIn, CZ_en, ALU_op, wIR, wAtmp, T1write;

  always #5 clk = ~clk;

  control_fsm dut (
    .clk            (clk),
    .proc_rst       (proc_rst),
    .IRout          (IRout),
    .compare        (compare),
    .Mux1_alu_B     (Mux1_alu_B),
    .Mux2_alu_A     (Mux2_alu_A),
    .Mux3_RF_wen    (Mux3_RF_wen),
    .Mux4_RF_wadd   (Mux4_RF_wadd),
    .Mux5_RF_read2  (Mux5_RF_read2),
    .Mux6_RF_dataIn (Mux6_RF_dataIn),
    .Mux8_memwrite  (Mux8_memwrite),
    .Mux9_memDataIn (Mux9_memDataIn),
    .CZ_en          (CZ_en),
    .ALU_op         (ALU_op),
    .wIR            (wIR),
    .wAtmp          (wAtmp),
    .T1write        (T1write),
    .counter        (counter)
  );

  logic [24:0] obs;
  assign obs = {Mux1_alu_B, Mux2_alu_A, Mux3_RF_wen, Mux4_RF_wadd, Mux5_RF_read2,
                Mux6_RF_dataIn, Mux8_memwrite, Mux9_memDataIn, CZ_en, ALU_op, wIR,
                wAtmp, T1write, counter};

  int n_checks = 0;
  int n_pass   = 0;

  logic [24:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Field order: aluB aluA wen wadd rd2 din memwr memdin cz aluop wir watmp t1w cnt
  function automatic logic [24:0] mk(int b, int a, int wen, int wadd, int rd2, int din,
                                     int mw, int md, int cz, int aop, int wir, int wat,
                                     int t1w, int cnt);
    return {3'(b), 3'(a), 2'(wen), 3'(wadd), 2'(rd2), 1'(din), 2'(mw), 1'(md),
            1'(cz), 1'(aop), 1'(wir), 1'(wat), 1'(t1w), 3'(cnt)};
  endfunction

  function automatic void push(string tag, logic [24:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endfunction

  // Expected cycle-by-cycle control for one instruction; cmp is the flag
  // presented during the compare cycle of a BEQ.
  function automatic void build(logic [15:0] ir, logic cmp);
    logic [3:0] op;
    op = ir[15:12];
    exp_q.delete();
    tag_q.delete();
    push("F_ADDR", mk(2, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    push("F_IR",   mk(2, 1, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    push("PC_WB",  mk(0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    case (op)
      4'h0, 4'h2: begin
        push("ALU_EX", mk(2, 5, 0, 0, 0, 0, 0, 0, 1, (op == 4'h2) ? 1 : 0, 0, 0, 1, 0));
        push("ALU_WB", mk(0, 0, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      4'h1: begin
        push("ADI_EX", mk(3, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        push("ADI_WB", mk(0, 0, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      4'h3: begin
        push("LHI_EX", mk(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        push("LHI_WB", mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      4'h4, 4'h5: begin
        push("ADDR", mk(2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        if (op == 4'h4) push("LW_MEM", mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        else            push("SW_MEM", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      end
      4'h6, 4'h7: begin
        for (int k = 0; k < 8; k++) begin
          push($sformatf("M_ADDR%0d", k), mk(4, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, k));
          if (op == 4'h6)
            push($sformatf("LM_XFER%0d", k), mk(0, 0, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, k));
          else
            push($sformatf("SM_XFER%0d", k), mk(0, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0, k));
        end
      end
      4'hC: begin
        push("BEQ_CMP", mk(2, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (cmp) begin
          push("BR_TGT", mk(2, 3, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0));
          push("BR_WB",  mk(0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        end
      end
      4'h8, 4'h9: begin
        if (op == 4'h8) push("JAL_LINK", mk(2, 4, 1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        else            push("JLR_LINK", mk(2, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        push("BR_WB", mk(0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      default: ;
    endcase
  endfunction

  // Cycles spent in RST after reset was sampled; reset released in the last.
  task automatic rst_seq(input int len);
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      proc_rst = (j < len - 1);
      compare  = 1'($urandom);
      #1 check("RST", obs, '0);
    end
  endtask

  // Runs one instruction; rst_at >= 0 raises reset in that cycle.
  task automatic run_instr(input logic [15:0] ir, input logic cmp, input int rst_at,
                           input int rst_len);
    build(ir, cmp);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      IRout    = ir;
      compare  = (ir[15:12] == 4'hC && i == 3) ? cmp : 1'($urandom);
      proc_rst = (i == rst_at);
      #1 check($sformatf("%s ir=%h", tag_q[i], ir), obs, exp_q[i]);
      if (i == rst_at) begin
        rst_seq(rst_len);
        return;
      end
    end
  endtask

  initial begin
    logic [15:0] ir;
    logic        cmp;
    int          len;
    int          rst_at;
    proc_rst = 1'b1;
    IRout    = 16'h0000;
    compare  = 1'b0;
    @(posedge clk);
    rst_seq(2);

    run_instr(16'h0298, 1'b0, -1, 1);
    run_instr(16'h2298, 1'b0, -1, 1);
    run_instr(16'hC245, 1'b1, -1, 1);
    run_instr(16'hC245, 1'b0, -1, 1);
    run_instr(16'h7055, 1'b0, -1, 1);
    run_instr(16'h7055, 1'b0, 10, 1);  // reset in M_XFER with counter = 3
    run_instr(16'hF000, 1'b0, -1, 1);
    run_instr(16'h6055, 1'b0, -1, 2);

    for (int n = 0; n < 300; n++) begin
      ir  = 16'($urandom);
      cmp = 1'($urandom);
      build(ir, cmp);
      len    = exp_q.size();
      rst_at = ($urandom_range(0, 15) == 0) ? $urandom_range(0, len - 1) : -1;
      run_instr(ir, cmp, rst_at, $urandom_range(1, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
